// File: rtl/pwl_pkg.sv
// Shared mode/segment types and fixed-point breakpoint constants for the
// piecewise-linear sigmoid/tanh activation.
package pwl_pkg;

  typedef enum logic {
    MODE_SIG  = 1'b0,
    MODE_TANH = 1'b1
  } mode_e;

  typedef enum logic [2:0] {
    SEG_LO  = 3'd0,
    SEG_NEG = 3'd1,
    SEG_MID = 3'd2,
    SEG_POS = 3'd3,
    SEG_HI  = 3'd4
  } seg_e;

  // Every breakpoint and coefficient is a whole number of eighths, so one
  // helper scales them all to any FRAC_W >= 3.
  localparam int BP_LO_8  = -19;  // -2.375
  localparam int BP_M1_8  = -8;   // -1.0
  localparam int BP_P1_8  = 8;    //  1.0
  localparam int BP_HI_8  = 19;   //  2.375
  localparam int C_NEG_8  = 3;    //  0.375
  localparam int C_MID_8  = 4;    //  0.5
  localparam int C_POS_8  = 5;    //  0.625
  localparam int ONE_8    = 8;    //  1.0

  function automatic longint eighths(input int frac_w, input int n);
    return (longint'(n) <<< frac_w) >>> 3;
  endfunction

endpackage

// File: rtl/pwl_segment.sv
// Combinational segment select and slope shift for the sigmoid approximation.
module pwl_segment
  import pwl_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int FRAC_W = 16
) (
  input  logic signed [DATA_W-1:0] x,
  output seg_e                     seg,
  output logic signed [DATA_W-1:0] shifted
);

  localparam logic signed [DATA_W-1:0] BP_LO = DATA_W'(eighths(FRAC_W, BP_LO_8));
  localparam logic signed [DATA_W-1:0] BP_M1 = DATA_W'(eighths(FRAC_W, BP_M1_8));
  localparam logic signed [DATA_W-1:0] BP_P1 = DATA_W'(eighths(FRAC_W, BP_P1_8));
  localparam logic signed [DATA_W-1:0] BP_HI = DATA_W'(eighths(FRAC_W, BP_HI_8));

  // Clamp segments contribute only their constant, so the slope term is zero.
  always_comb begin
    seg     = SEG_MID;
    shifted = x >>> 2;
    if (x < BP_LO) begin
      seg     = SEG_LO;
      shifted = '0;
    end else if (x < BP_M1) begin
      seg     = SEG_NEG;
      shifted = x >>> 3;
    end else if (x < BP_P1) begin
      seg     = SEG_MID;
      shifted = x >>> 2;
    end else if (x < BP_HI) begin
      seg     = SEG_POS;
      shifted = x >>> 3;
    end else begin
      seg     = SEG_HI;
      shifted = '0;
    end
  end

endmodule

// File: rtl/pwl_activation.sv
// Three-stage piecewise-linear sigmoid / tanh with valid-ready handshake.
// Tanh mode is built only when macro PWL_TANH_EN is defined.
module pwl_activation
  import pwl_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int FRAC_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     in_mode,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]         sat_cnt,
  output logic                     busy
);

  localparam int SUM_W = DATA_W + 1;
  localparam logic signed [SUM_W-1:0] C_NEG_S = SUM_W'(eighths(FRAC_W, C_NEG_8));
  localparam logic signed [SUM_W-1:0] C_MID_S = SUM_W'(eighths(FRAC_W, C_MID_8));
  localparam logic signed [SUM_W-1:0] C_POS_S = SUM_W'(eighths(FRAC_W, C_POS_8));
  localparam logic signed [SUM_W-1:0] ONE_S   = SUM_W'(eighths(FRAC_W, ONE_8));

  logic                     adv;
  logic signed [DATA_W-1:0] x_pre;
  seg_e                     seg;
  logic signed [DATA_W-1:0] shifted;
  logic signed [SUM_W-1:0]  coef;
  logic signed [SUM_W-1:0]  sum_next;
  logic signed [SUM_W-1:0]  sig_clamped;
  logic signed [DATA_W-1:0] y_next;

  logic                     s1_valid_reg;
  seg_e                     s1_seg_reg;
  logic signed [DATA_W-1:0] s1_shift_reg;
  logic                     s2_valid_reg;
  logic signed [SUM_W-1:0]  s2_sum_reg;
  logic                     s2_sat_reg;
  logic                     out_valid_reg;
  logic signed [DATA_W-1:0] out_data_reg;
  logic                     out_sat_reg;
  logic [CNT_W-1:0]         sat_cnt_reg;

  assign adv       = !out_valid_reg || out_ready;
  assign in_ready  = adv;
  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign sat_cnt   = sat_cnt_reg;
  assign busy      = s1_valid_reg || s2_valid_reg || out_valid_reg;

`ifdef PWL_TANH_EN
  localparam logic signed [SUM_W-1:0] NEG_ONE_S = SUM_W'(eighths(FRAC_W, -ONE_8));
  mode_e                   s1_mode_reg;
  mode_e                   s2_mode_reg;
  logic signed [SUM_W-1:0] tanh_val;

  // tanh(x) = 2*sig(2x) - 1; doubling saturates instead of wrapping.
  always_comb begin
    x_pre = in_data;
    if (in_mode == MODE_TANH) begin
      if (in_data[DATA_W-1] != in_data[DATA_W-2])
        x_pre = in_data[DATA_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
      else
        x_pre = in_data <<< 1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1_mode_reg <= MODE_SIG;
      s2_mode_reg <= MODE_SIG;
    end else if (adv) begin
      s1_mode_reg <= mode_e'(in_mode);
      s2_mode_reg <= s1_mode_reg;
    end
  end
`else
  logic in_mode_unused;
  assign in_mode_unused = in_mode;
  assign x_pre          = in_data;
`endif

  pwl_segment #(
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W)
  ) u_segment (
    .x       (x_pre),
    .seg     (seg),
    .shifted (shifted)
  );

  always_comb begin
    coef = '0;
    case (s1_seg_reg)
      SEG_NEG: coef = C_NEG_S;
      SEG_MID: coef = C_MID_S;
      SEG_POS: coef = C_POS_S;
      SEG_HI:  coef = ONE_S;
      default: coef = '0;
    endcase
  end

  assign sum_next = {s1_shift_reg[DATA_W-1], s1_shift_reg} + coef;

  always_comb begin
    sig_clamped = s2_sum_reg;
    if (s2_sum_reg[SUM_W-1])
      sig_clamped = '0;
    else if (s2_sum_reg > ONE_S)
      sig_clamped = ONE_S;
`ifdef PWL_TANH_EN
    tanh_val = (sig_clamped <<< 1) - ONE_S;
    if (tanh_val > ONE_S)
      tanh_val = ONE_S;
    else if (tanh_val < NEG_ONE_S)
      tanh_val = NEG_ONE_S;
    y_next = (s2_mode_reg == MODE_TANH) ? tanh_val[DATA_W-1:0] : sig_clamped[DATA_W-1:0];
`else
    y_next = sig_clamped[DATA_W-1:0];
`endif
  end

  // A single advance enable moves every stage together, so a stall freezes
  // the whole pipe and the output register holds its value.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1_valid_reg  <= 1'b0;
      s1_seg_reg    <= SEG_LO;
      s1_shift_reg  <= '0;
      s2_valid_reg  <= 1'b0;
      s2_sum_reg    <= '0;
      s2_sat_reg    <= 1'b0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_sat_reg   <= 1'b0;
      sat_cnt_reg   <= '0;
    end else begin
      sat_cnt_reg <= sat_cnt_reg + CNT_W'(out_valid_reg && out_ready && out_sat_reg);
      if (adv) begin
        s1_valid_reg  <= in_valid;
        s1_seg_reg    <= seg;
        s1_shift_reg  <= shifted;
        s2_valid_reg  <= s1_valid_reg;
        s2_sum_reg    <= sum_next;
        s2_sat_reg    <= (s1_seg_reg == SEG_LO) || (s1_seg_reg == SEG_HI);
        out_valid_reg <= s2_valid_reg;
        out_data_reg  <= y_next;
        out_sat_reg   <= s2_sat_reg;
      end
    end
  end

endmodule

// File: tb/tb_pwl_activation.sv
// Scoreboard bench for pwl_activation: a real-arithmetic reference model
// predicts each accepted sample, a monitor checks results as they leave.
module tb_pwl_activation;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [15:0] sat_cnt;
  logic        busy;

  pwl_activation #(.DATA_W(32), .FRAC_W(16), .CNT_W(16)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .sat_cnt   (sat_cnt),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] exp;
    bit          sat;
    int          acc;
    bit          lat;
  } sb_t;

  sb_t         sb_q[$];
  int          n_checks = 0;
  int          n_err = 0;
  int          n_out = 0;
  int          cyc = 0;
  int          ready_mode = 0;
  int          preload_gen = 0;
  bit          dir_en = 0;
  logic [31:0] dir_exp = '0;
  bit          lat_en = 0;
  logic [15:0] model_sat = '0;

  localparam longint MAXV = 64'sh7FFF_FFFF;
  localparam longint MINV = -64'sh8000_0000;

  function automatic void chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference: the segment table evaluated with real arithmetic in LSB units.
  function automatic void model(input logic [31:0] d, input logic m, output logic [31:0] y,
                                output bit sat);
    real    one, xr, s;
    longint x;
    bit     th;
    one = 65536.0;
    x   = longint'(signed'(d));
`ifdef PWL_TANH_EN
    th = m;
`else
    th = m & 1'b0;
`endif
    if (th) begin
      x = 2 * x;
      if (x > MAXV) x = MAXV;
      if (x < MINV) x = MINV;
    end
    xr  = real'(x);
    sat = 1'b0;
    if (xr < -2.375 * one) begin
      s = 0.0; sat = 1'b1;
    end else if (xr < -one) s = $floor(xr / 8.0) + 0.375 * one;
    else if (xr < one)      s = $floor(xr / 4.0) + 0.5 * one;
    else if (xr < 2.375 * one) s = $floor(xr / 8.0) + 0.625 * one;
    else begin
      s = one; sat = 1'b1;
    end
    if (s < 0.0) s = 0.0;
    if (s > one) s = one;
    if (th) begin
      s = 2.0 * s - one;
      if (s > one) s = one;
      if (s < -one) s = -one;
    end
    y = 32'(longint'(s));
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin : ready_gen
    int stall_cnt;
    stall_cnt = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 2) begin
        if (out_valid) stall_cnt++;
        out_ready = (stall_cnt >= 5);
      end else begin
        stall_cnt = 0;
        out_ready = (ready_mode == 1) ? ($urandom_range(3) != 0) : 1'b1;
      end
    end
  end

  initial begin : in_mon
    sb_t         e;
    logic [31:0] m;
    bit          s;
    forever begin
      @(negedge clk);
      if (rstn && in_valid && in_ready) begin
        model(in_data, in_mode, m, s);
        e.exp = dir_en ? dir_exp : m;
        e.sat = s;
        e.acc = cyc;
        e.lat = lat_en;
        sb_q.push_back(e);
      end
    end
  end

  initial begin : out_mon
    sb_t e;
    int  seen_gen;
    seen_gen = 0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        sb_q.delete();
        model_sat = '0;
      end else begin
        if (preload_gen != seen_gen) begin
          seen_gen  = preload_gen;
          model_sat = 16'hFFFF;
        end
        if (out_valid) begin
          if (sb_q.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL unexpected_out: got out_data=%h expected no output", out_data);
          end else begin
            e = sb_q[0];
            chk("out_data", longint'(out_data), longint'(e.exp));
            if (!out_ready) begin
              chk("in_ready_stall", longint'(in_ready), 0);
            end else begin
              chk("sat_cnt", longint'(sat_cnt), longint'(model_sat));
              if (e.lat) chk("latency", longint'(cyc - e.acc), 3);
              $display("out #%0d data=%h exp=%h sat=%0d sat_cnt=%h", n_out, out_data, e.exp,
                       e.sat, sat_cnt);
              if (e.sat) model_sat = model_sat + 16'd1;
              void'(sb_q.pop_front());
              n_out++;
            end
          end
        end
      end
    end
  end

  task automatic send(input logic [31:0] d, input logic m, input bit use_exp,
                      input logic [31:0] x, input bit lat);
    int w;
    w        = 0;
    in_data  = d;
    in_mode  = m;
    dir_en   = use_exp;
    dir_exp  = x;
    lat_en   = lat;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      w++;
      if (w > 200) begin
        chk("accept_timeout", w, 0);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dir_en   = 1'b0;
    lat_en   = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((sb_q.size() != 0 || busy) && w < 300) begin
      @(posedge clk);
      #1;
      w++;
    end
    chk("drain_pending", sb_q.size(), 0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [31:0] bnd [12] = '{32'hFFFD_A000, 32'hFFFF_0000, 32'h0001_0000, 32'h0002_6000,
                            32'h0001_3000, 32'hFFFE_D000, 32'h0000_8000, 32'hFFFF_8000,
                            32'h4000_0000, 32'hC000_0000, 32'h7FFF_FFFF, 32'h8000_0000};

  initial begin : driver
    logic [31:0] d;
    bit          quiet_bad;
    rstn     = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_mode  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_sat_cnt", sat_cnt, 0);
    chk("rst_out_data", out_data, 0);
    rstn = 1'b1;
    idle(2);

    // Known sigmoid points, one at a time so latency is measured on an idle pipe.
    send(32'h0000_0000, 1'b0, 1'b1, 32'h0000_8000, 1'b1); drain();
    send(32'h0001_0000, 1'b0, 1'b1, 32'h0000_C000, 1'b1); drain();
    send(32'hFFFF_0000, 1'b0, 1'b1, 32'h0000_4000, 1'b1); drain();
    send(32'hFFFD_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1); drain();
    send(32'h0002_6000, 1'b0, 1'b1, 32'h0001_0000, 1'b1); drain();
    chk("sat_cnt_after_clamps", sat_cnt, 2);

`ifdef PWL_TANH_EN
    send(32'h0000_4000, 1'b1, 1'b1, 32'h0000_4000, 1'b1); drain();
    send(32'h0000_0000, 1'b1, 1'b1, 32'h0000_0000, 1'b1); drain();
    send(32'h7FFF_FFFF, 1'b1, 1'b1, 32'h0001_0000, 1'b1); drain();
`else
    send(32'h0000_4000, 1'b1, 1'b0, 32'h0, 1'b1); drain();
    send(32'h0000_0000, 1'b1, 1'b0, 32'h0, 1'b1); drain();
    send(32'h7FFF_FFFF, 1'b1, 1'b0, 32'h0, 1'b1); drain();
`endif

    // Random mixed-mode stream with random gaps and random backpressure.
    ready_mode = 1;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(3))
        0: d = $urandom;
        1: d = 32'(int'($urandom_range(524288)) - 262144);
        default: d = bnd[$urandom_range(11)] + 32'($urandom_range(2)) - 32'd1;
      endcase
      send(d, 1'($urandom_range(1)), 1'b0, 32'h0, 1'b0);
      if ($urandom_range(3) == 0) idle(1);
    end
    drain();
    ready_mode = 0;
    idle(2);

    // Four back-to-back samples into a stalled output.
    ready_mode = 2;
    for (int i = 0; i < 4; i++)
      send(32'(int'($urandom_range(393216)) - 196608), 1'($urandom_range(1)), 1'b0, 32'h0, 1'b0);
    drain();
    ready_mode = 0;
    idle(2);

    // Reset one cycle after two accepted samples discards both.
    send(32'hFFFD_0000, 1'b0, 1'b0, 32'h0, 1'b0);
    send(32'h0003_0000, 1'b0, 1'b0, 32'h0, 1'b0);
    rstn = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_sat_cnt", sat_cnt, 0);
    chk("mid_rst_busy", busy, 0);
    quiet_bad = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) quiet_bad = 1'b1;
    end
    chk("post_rst_quiet", quiet_bad, 0);
    @(posedge clk);
    #1;

    // Counter wrap from all-ones.
    force dut.sat_cnt_reg = 16'hFFFF;
    preload_gen++;
    @(posedge clk);
    #1;
    release dut.sat_cnt_reg;
    idle(1);
    chk("sat_cnt_preload", sat_cnt, 16'hFFFF);
    send(32'hFFFD_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b0);
    drain();
    chk("sat_cnt_wrap", sat_cnt, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pwl_activation.md
PWL_ACTIVATION -- requirements
Module: pwl_activation

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning signed two's-complement sample width.
REQ-002 The block SHALL have parameter FRAC_W, default 16, meaning fractional bits of input and output (Q(DATA_W-FRAC_W).FRAC_W).
REQ-003 The block SHALL have parameter CNT_W, default 16, meaning width of the saturation event counter.
REQ-004 The block SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-005 The block SHALL have port rstn  input  1  reset; one clock, reset synchronous, active-low.
REQ-006 The block SHALL have port in_valid  input  1  sample offered.
REQ-007 The block SHALL have port in_ready  output  1  sample accepted when in_valid and in_ready are both high.
REQ-008 The block SHALL have port in_data  input  DATA_W  signed input x.
REQ-009 The block SHALL have port in_mode  input  1  0 = sigmoid, 1 = tanh; sampled with in_data.
REQ-010 The block SHALL have port out_valid  output  1  result available.
REQ-011 The block SHALL have port out_ready  input  1  downstream accepts the result.
REQ-012 The block SHALL have port out_data  output  DATA_W  signed result, same Q format as input.
REQ-013 The block SHALL have port sat_cnt  output  CNT_W  count of results that hit a clamp segment.
REQ-014 The block SHALL have port busy  output  1  high while any pipeline stage holds a valid sample.

Function
REQ-015 All breakpoint comparisons SHALL be signed.
REQ-016 Sigmoid segments SHALL be: x<-2.375 -> 0; -2.375<=x<-1 -> x/8+0.375; -1<=x<1 -> x/4+0.5; 1<=x<2.375 -> x/8+0.625; x>=2.375 -> 1.0.
REQ-017 Divisions SHALL be arithmetic right shifts (floor); the sum SHALL be formed at DATA_W+1 bits, then clamped to [0, 1.0].
REQ-018 Tanh mode SHALL compute 2*sig(2x)-1; 2x SHALL saturate to the DATA_W signed range; the final result SHALL be clamped to [-1.0, 1.0].
REQ-019 The pipeline SHALL have three stages: S1 = mode pre-scale, segment select, shift; S2 = coefficient add; S3 = clamp, tanh post-scale, output register.
REQ-020 Latency SHALL be 3 cycles from handshake to out_valid when out_ready is held high; throughput SHALL be one sample per cycle.
REQ-021 The advance enable SHALL be adv = !out_valid || out_ready; in_ready SHALL equal adv; all stages SHALL hold when adv is low.
REQ-022 out_data SHALL be stable while out_valid && !out_ready; no sample SHALL be lost, duplicated or reordered.
REQ-023 A simultaneous output handshake and input handshake SHALL both complete in the same cycle.
REQ-024 sat_cnt SHALL increment by 1 on each output handshake whose sample fell in the lowest or highest segment, and SHALL wrap from all-ones to 0.
REQ-025 Mode SHALL travel with its sample, so mixed-mode streams are legal back-to-back.

Reset
REQ-026 When rstn is low at a clock edge, all stage valids, out_valid, busy and sat_cnt SHALL be 0, out_data SHALL be 0 and in_ready SHALL be 1.
REQ-027 Reset asserted mid-operation SHALL discard in-flight samples, with no output handshake in that cycle.

Configuration
REQ-028 With macro PWL_TANH_EN defined, tanh mode SHALL be built; without it, in_mode SHALL be ignored, all samples SHALL be processed as sigmoid, and the tanh pre/post logic SHALL be absent.

Structure
REQ-029 Package pwl_pkg SHALL hold the mode enum and the breakpoint/coefficient constants, expressed as functions of FRAC_W (values -2.375, -1, 1, 2.375, 0.375, 0.5, 0.625, 1.0).
REQ-030 Sub-module pwl_segment SHALL hold the combinational segment select and shift; the pipeline and handshake SHALL stay in pwl_activation.

Verification (DATA_W=32, FRAC_W=16)
REQ-031 Sigmoid, in_data 0x00000000 / 0x00010000 / 0xFFFF0000 -> 0x00008000 / 0x0000C000 / 0x00004000, each 3 cycles after accept.
REQ-032 Sigmoid, in_data 0xFFFD0000 (-3.0) -> 0x00000000 with sat_cnt +1; in_data 0x00026000 (2.375) -> 0x00010000 with sat_cnt +1.
REQ-033 Tanh, in_data 0x00004000 (0.25) -> 0x00004000; in_data 0x00000000 -> 0x00000000; in_data 0x7FFFFFFF -> 0x00010000.
REQ-034 Backpressure: 4 back-to-back samples with out_ready low for 5 cycles -> in_ready low while stalled, out_data stable, all 4 results delivered in order.
REQ-035 Reset pulse 1 cycle after 2 samples accepted -> no out_valid afterwards, sat_cnt = 0, in_ready = 1 next cycle.
REQ-036 sat_cnt preloaded to 0xFFFF by forcing, then one clamped result -> sat_cnt = 0x0000.
